// File: rtl/pin_receiver_if.sv
// Keypad/controller bundle of the PIN receiver: entry inputs, stored PIN and
// the registered verdict outputs. The master side drives entry, the slave is the receiver.
interface pin_receiver_if;
    logic        tarjeta_recibida;
    logic        digito_stb;
    logic [3:0]  digito;
    logic [15:0] pin_correcto;
    logic        pin_incorrecto;
    logic        advertencia;
    logic        bloqueo;
    logic        fin;
    logic [15:0] pin;

    modport master (
        output tarjeta_recibida, digito_stb, digito, pin_correcto,
        input  pin_incorrecto, advertencia, bloqueo, fin, pin
    );

    modport slave (
        input  tarjeta_recibida, digito_stb, digito, pin_correcto,
        output pin_incorrecto, advertencia, bloqueo, fin, pin
    );
endinterface

// File: rtl/pin_receiver.sv
// PIN entry and verification for the ATM controller: collects four strobed
// digits after card detection, compares against the stored PIN, tracks failures.
module pin_receiver #(
    parameter int MAX_INTENTOS        = 3,
    parameter int INTENTO_ADVERTENCIA = 2
) (
    input  logic          clk,
    input  logic          reset,
    pin_receiver_if.slave bus
);

    localparam int CW = $clog2(MAX_INTENTOS + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_INTENTOS);
    localparam logic [CW-1:0] ADV_C = CW'(INTENTO_ADVERTENCIA);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    localparam logic [1:0] ESPERA_TARJETA = 2'd0;
    localparam logic [1:0] RECIBIENDO     = 2'd1;
    localparam logic [1:0] VERIFICAR      = 2'd2;
    localparam logic [1:0] BLOQUEO        = 2'd3;

    logic [1:0]    state_r,    state_s;
    logic [2:0]    cnt_r,      cnt_s;
    logic [CW-1:0] intentos_r, intentos_s;
    logic [CW-1:0] intentos_inc_s;
    logic [15:0]   pin_r,      pin_s;
    logic          stb_prev_r;
    logic          captura_s;
    logic          fin_r,      fin_s;
    logic          bad_r,      bad_s;
    logic          adv_r,      adv_s;
    logic          bloq_r,     bloq_s;

    assign captura_s      = bus.digito_stb & ~stb_prev_r;
    // The failure counter never wraps past the lockout threshold.
    assign intentos_inc_s = (intentos_r >= MAX_C) ? intentos_r : intentos_r + ONE_C;

    // Next-state and output computation for the entry/verification FSM.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        intentos_s = intentos_r;
        pin_s      = pin_r;
        fin_s      = 1'b0;
        bad_s      = 1'b0;
        adv_s      = adv_r;
        bloq_s     = bloq_r;
        case (state_r)
            ESPERA_TARJETA: begin
                if (bus.tarjeta_recibida) begin
                    state_s = RECIBIENDO;
                    cnt_s   = 3'd0;
                end else begin
                    state_s = ESPERA_TARJETA;
                end
            end
            RECIBIENDO: begin
                if (captura_s) begin
                    // First digit of an attempt discards the previous attempt's PIN.
                    if (cnt_r == 3'd0) begin
                        pin_s = {12'h000, bus.digito};
                    end else begin
                        pin_s = {pin_r[11:0], bus.digito};
                    end
                    cnt_s = cnt_r + 3'd1;
                    if (cnt_r == 3'd3) begin
                        state_s = VERIFICAR;
                    end else begin
                        state_s = RECIBIENDO;
                    end
                end else begin
                    state_s = RECIBIENDO;
                end
            end
            VERIFICAR: begin
                cnt_s = 3'd0;
                if (pin_r == bus.pin_correcto) begin
                    fin_s      = 1'b1;
                    intentos_s = {CW{1'b0}};
                    adv_s      = 1'b0;
                    state_s    = ESPERA_TARJETA;
                end else begin
                    bad_s      = 1'b1;
                    intentos_s = intentos_inc_s;
                    if (intentos_inc_s == MAX_C) begin
                        bloq_s  = 1'b1;
                        adv_s   = 1'b0;
                        state_s = BLOQUEO;
                    end else if (intentos_inc_s == ADV_C) begin
                        adv_s   = 1'b1;
                        state_s = RECIBIENDO;
                    end else begin
                        state_s = RECIBIENDO;
                    end
                end
            end
            BLOQUEO: begin
                bloq_s  = 1'b1;
                state_s = BLOQUEO;
            end
            default: begin
                state_s = ESPERA_TARJETA;
            end
        endcase
    end

    // State, strobe history and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ESPERA_TARJETA;
            cnt_r      <= 3'd0;
            intentos_r <= {CW{1'b0}};
            pin_r      <= 16'h0000;
            stb_prev_r <= 1'b0;
            fin_r      <= 1'b0;
            bad_r      <= 1'b0;
            adv_r      <= 1'b0;
            bloq_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            intentos_r <= intentos_s;
            pin_r      <= pin_s;
            stb_prev_r <= bus.digito_stb;
            fin_r      <= fin_s;
            bad_r      <= bad_s;
            adv_r      <= adv_s;
            bloq_r     <= bloq_s;
        end
    end

    assign bus.pin            = pin_r;
    assign bus.fin            = fin_r;
    assign bus.pin_incorrecto = bad_r;
    assign bus.advertencia    = adv_r;
    assign bus.bloqueo        = bloq_r;

endmodule

// File: tb/tb_pin_receiver.sv
// Self-checking bench for pin_receiver: directed scenarios plus randomized
// sessions against an attempt-level reference model.
module tb_pin_receiver;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pin_receiver_if bus ();

    pin_receiver #(.MAX_INTENTOS(3), .INTENTO_ADVERTENCIA(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: card session, digits of the current attempt, verdicts.
    bit          m_card, m_lock, m_adv, m_fin, m_bad;
    int          m_fails;
    logic [3:0]  m_digits[$];
    logic [15:0] m_pin;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".pin"},            bus.pin,                     m_pin);
        chk({tag, ".fin"},            {15'd0, bus.fin},            {15'd0, m_fin});
        chk({tag, ".pin_incorrecto"}, {15'd0, bus.pin_incorrecto}, {15'd0, m_bad});
        chk({tag, ".advertencia"},    {15'd0, bus.advertencia},    {15'd0, m_adv});
        chk({tag, ".bloqueo"},        {15'd0, bus.bloqueo},        {15'd0, m_lock});
    endtask

    task automatic model_clear();
        m_card = 1'b0; m_lock = 1'b0; m_adv = 1'b0; m_fin = 1'b0; m_bad = 1'b0;
        m_fails = 0;
        m_digits.delete();
        m_pin = 16'h0000;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.tarjeta_recibida = 1'b0;
        bus.digito_stb = 1'b0;
        bus.digito = 4'h0;
        model_clear();
        tick();
        tick();
        chk_all("in_reset");
        reset = 1'b1;
        tick();
        chk_all("after_reset");
    endtask

    task automatic card_in(input bit v);
        bus.tarjeta_recibida = v;
        tick();
        if (v && !m_lock) m_card = 1'b1;
    endtask

    // Apply one digit to the model at the level of "an attempt is four digits".
    task automatic model_digit(input logic [3:0] d);
        int val;
        if (m_card && !m_lock) begin
            m_digits.push_back(d);
            val = 0;
            foreach (m_digits[i]) val = val * 16 + int'(m_digits[i]);
            m_pin = 16'(val);
            if (m_digits.size() == 4) begin
                m_digits.delete();
                if (m_pin == bus.pin_correcto) begin
                    m_fin = 1'b1; m_fails = 0; m_adv = 1'b0; m_card = 1'b0;
                end else begin
                    m_bad = 1'b1;
                    if (m_fails < 3) m_fails++;
                    if (m_fails == 3) begin
                        m_lock = 1'b1; m_adv = 1'b0;
                    end else if (m_fails == 2) begin
                        m_adv = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic send(input logic [3:0] d, input int hold);
        bit result;
        bus.digito = d;
        bus.digito_stb = 1'b1;
        tick();
        model_digit(d);
        result = m_fin || m_bad;
        if (!result) repeat (hold - 1) tick();
        bus.digito_stb = 1'b0;
        tick();
        chk_all(result ? "verdict" : "digit");
        if (result) begin
            m_fin = 1'b0;
            m_bad = 1'b0;
            tick();
            chk_all("verdict_end");
            if (!m_lock && !m_card) m_card = bus.tarjeta_recibida;
        end
    endtask

    task automatic send_pin(input logic [15:0] p, input int maxhold);
        for (int i = 3; i >= 0; i--) send(p[4*i +: 4], $urandom_range(maxhold, 1));
    endtask

    initial begin
        logic [15:0] pc, guess;
        reset = 1'b1;
        bus.pin_correcto = 16'h1234;
        do_reset();

        // Correct PIN on first try.
        card_in(1'b1);
        send_pin(16'h1234, 1);

        // One wrong then correct: warning never raised.
        send_pin(16'h5678, 1);
        send_pin(16'h1234, 2);

        // Two wrong raise the warning; correct clears it.
        send_pin(16'h9999, 1);
        send_pin(16'h9999, 1);
        chk("adv_after_two", {15'd0, bus.advertencia}, 16'h0001);
        send_pin(16'h1234, 1);

        // Three wrong: lockout, strobes ignored, reset releases.
        send_pin(16'h0000, 1);
        send_pin(16'hFFFF, 1);
        bus.tarjeta_recibida = 1'b0;
        send_pin(16'h4321, 3);
        chk("locked", {15'd0, bus.bloqueo}, 16'h0001);
        send(4'h7, 1);
        send(4'h8, 2);
        do_reset();

        // Held strobe counts once; strobes before the card are ignored.
        send(4'h5, 1);
        send(4'h6, 2);
        card_in(1'b1);
        send(4'hA, 5);
        chk("held_once", bus.pin, 16'h000A);
        do_reset();

        // Randomized sessions.
        for (int s = 0; s < 6; s++) begin
            pc = 16'($urandom);
            bus.pin_correcto = pc;
            for (int a = 0; a < 6 && !m_lock; a++) begin
                if (!m_card) card_in(1'b1);
                guess = ($urandom_range(2, 0) == 0) ? pc : 16'($urandom);
                if ($urandom_range(3, 0) == 0) bus.tarjeta_recibida = 1'b0;
                send_pin(guess, 3);
            end
            send(4'($urandom), 1);
            do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pin_receiver.md
Name: pin_receiver

Overview:
- PIN-entry and verification block of the automatic cashier (ATM) controller.
- After a card is detected, it collects four 4-bit digits, one per strobe, and compares the assembled 16-bit PIN against the stored correct PIN.
- Reports success, failure, warning and lockout to the transaction controller.
- Sits between the keypad interface and the main ATM FSM.

Parameters:
MAX_INTENTOS, 3, number of failed attempts that causes lockout.
INTENTO_ADVERTENCIA, 2, failed-attempt count at which advertencia asserts.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-low reset.
tarjeta_recibida  input  1  card inserted; sampled only in ESPERA_TARJETA.
digito_stb  input  1  digit strobe; a rising edge marks one new digit.
digito  input  4  digit value, valid while digito_stb is high; any nibble 0x0-0xF is accepted.
pin_correcto  input  16  stored correct PIN; first digit is in bits [15:12].
pin_incorrecto  output  1  one-cycle pulse per failed comparison.
advertencia  output  1  level: one failed attempt remains.
bloqueo  output  1  level: card locked; sticky until reset.
fin  output  1  one-cycle pulse on correct PIN.
pin  output  16  PIN assembled so far, for observation and debug.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset (reset=0): all outputs go to 0, pin=16'h0000, digit count=0, attempt count=0, stb_prev=0, state=ESPERA_TARJETA.
- All outputs are registered.
- Strobe edge detection:
  - stb_prev holds registered digito_stb.
  - A digit is captured at an edge where digito_stb=1 and stb_prev=0.
  - A strobe held high for several cycles counts once.
- States:
  - ESPERA_TARJETA:
    - If tarjeta_recibida=1 → RECIBIENDO, digit count=0.
    - Strobes are ignored.
  - RECIBIENDO:
    - On each captured digit, pin <= {pin[11:0], digito} and count++.
    - The first digit of an attempt instead loads pin <= {12'h000, digito}, clearing the previous attempt.
    - When the 4th digit is captured (edge k) → VERIFICAR.
  - VERIFICAR (one cycle; strobes here are ignored and do not update stb_prev semantics beyond normal registering):
    - At edge k+1, if pin == pin_correcto: fin=1, attempt count=0, advertencia=0, → ESPERA_TARJETA.
    - Otherwise: pin_incorrecto=1 and attempt count++.
      - New count == INTENTO_ADVERTENCIA: advertencia=1.
      - New count == MAX_INTENTOS: bloqueo=1, advertencia=0, → BLOQUEO.
      - Else → RECIBIENDO with digit count=0.
  - BLOQUEO: absorbing; all inputs ignored; bloqueo stays 1 and pin holds its value until reset.
- Latency: fin or pin_incorrecto is visible one cycle after the 4th digit is captured, and deasserts at edge k+2.
- pin holds its last value through the result cycle and afterwards, until the next attempt's first digit or reset.
- tarjeta_recibida dropping mid-entry has no effect; the block finishes the attempt.
- The attempt counter saturates at MAX_INTENTOS.
- Reset mid-operation aborts immediately to the reset state, including from BLOQUEO.

Test Plan:
- Reset held low 2 cycles, then released → all outputs 0, pin=0000.
- tarjeta_recibida=1, pin_correcto=16'h1234, strobes with digits 1,2,3,4 → pin=1234; fin pulses 1 cycle after the 4th digit; pin_incorrecto=0.
- Card in, pin_correcto=16'h1234, enter 5,6,7,8 → pin_incorrecto pulse; advertencia=0; then enter 1,2,3,4 → fin pulse, advertencia stays 0.
- Two wrong PINs (9,9,9,9 twice) → two pin_incorrecto pulses; advertencia=1 after the second; then the correct PIN → fin=1 and advertencia clears.
- Three wrong PINs → third pin_incorrecto pulse with bloqueo=1 on the same edge, advertencia=0; further strobes do not change pin; reset low → bloqueo=0.
- digito_stb held high 5 cycles with digito=A → only one digit captured (pin=000A); strobes before tarjeta_recibida are ignored.
